multi_timer: RTL and testbench

- Memory-mapped, parametrised multi-channel timer peripheral on the CPU's shared address/data bus.
- Replaces the single fixed timer. A shared prescaler produces a tick every TICK_DIV clocks. NUM_CH independent channels each count ticks against their own limit.
- Each channel has a ready flag and an overflow flag, auto-reload or one-shot mode, and a run gate.
- A single level interrupt output ORs all enabled ready flags toward the interrupt controller.

---
 rtl/multi_timer.sv | 146 ++++++++++++++
 tb/tb_multi_timer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_timer.sv
`default_nettype none
// ============================================================================
// Module   : multi_timer
// Brief    : Bus-mapped multi-channel timer. A shared prescaler ticks every
//            TICK_DIV clocks; each channel counts ticks against its own limit
//            with ready/overflow flags, one-shot mode, a run gate and an
//            interrupt enable. The enabled ready flags are ORed into intr.
// Revision : 1.0 - initial release
// ============================================================================
module multi_timer #(
    parameter int unsigned ABUS_WIDTH      = 32,
    parameter int unsigned DBUS_WIDTH      = 32,
    parameter int unsigned NUM_CH          = 2,
    parameter logic [31:0] TICK_DIV        = 32'd50000,
    parameter logic [31:0] CNT_BASE        = 32'hF0000020,
    parameter logic [31:0] CTL_BASE        = 32'hF0000120,
    parameter logic [8:0]  CTL_RESET_VALUE = 9'h002
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ABUS_WIDTH-1:0] aBus,
    inout  wire  [DBUS_WIDTH-1:0] dBus,
    input  logic                  wrtEn,
    output logic                  intr
);

    // Implemented CTL bits: IE[8], ONESHOT[4], OVF[2], RUN[1], READY[0].
    localparam logic [8:0]  c_CTL_MASK  = 9'h117;
    localparam logic [31:0] c_TICK_LAST = TICK_DIV - 32'd1;

    logic [31:0]           r_presc;
    logic                  w_tick;
    logic [NUM_CH-1:0]     w_rdHitCh;
    logic [NUM_CH-1:0]     w_irqCh;
    logic [DBUS_WIDTH-1:0] w_rdDataCh [NUM_CH];
    logic [DBUS_WIDTH-1:0] w_rdData;
    logic                  w_rdHit;

    assign w_tick = (r_presc == c_TICK_LAST);

    // Shared prescaler: 0..TICK_DIV-1, wrapping on the tick clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= 32'd0;
        end else if (w_tick) begin
            r_presc <= 32'd0;
        end else begin
            r_presc <= r_presc + 32'd1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [ABUS_WIDTH-1:0] c_CNT_ADDR = ABUS_WIDTH'(CNT_BASE + 32'(8 * i));
        localparam logic [ABUS_WIDTH-1:0] c_LIM_ADDR = ABUS_WIDTH'(CNT_BASE + 32'(8 * i + 4));
        localparam logic [ABUS_WIDTH-1:0] c_CTL_ADDR = ABUS_WIDTH'(CTL_BASE + 32'(4 * i));

        logic [DBUS_WIDTH-1:0] r_cnt;
        logic [DBUS_WIDTH-1:0] r_lim;
        logic [8:0]            r_ctl;
        logic [8:0]            w_ctlNext;
        logic [8:0]            w_ctlWrVal;
        logic                  w_cntSel;
        logic                  w_limSel;
        logic                  w_ctlSel;
        logic                  w_cntWr;
        logic                  w_limWr;
        logic                  w_ctlWr;
        logic                  w_expire;

        assign w_cntSel   = (aBus == c_CNT_ADDR);
        assign w_limSel   = (aBus == c_LIM_ADDR);
        assign w_ctlSel   = (aBus == c_CTL_ADDR);
        assign w_cntWr    = wrtEn & w_cntSel;
        assign w_limWr    = wrtEn & w_limSel;
        assign w_ctlWr    = wrtEn & w_ctlSel;
        assign w_ctlWrVal = dBus[8:0] & c_CTL_MASK;

        // A CNT write in the tick cycle suppresses expiry; the compare always
        // uses the pre-write LIM.
        assign w_expire = w_tick & r_ctl[1] & (r_lim != '0)
                        & (r_cnt == r_lim - DBUS_WIDTH'(1)) & ~w_cntWr;

        // Next CTL: SW can only clear READY/OVF, and a same-cycle expiry set wins.
        always_comb begin
            w_ctlNext = r_ctl;
            if (w_ctlWr) begin
                w_ctlNext    = w_ctlWrVal;
                w_ctlNext[0] = r_ctl[0] & w_ctlWrVal[0];
                w_ctlNext[2] = r_ctl[2] & w_ctlWrVal[2];
            end else if (w_expire & r_ctl[4]) begin
                w_ctlNext[1] = 1'b0;
            end
            if (w_expire) begin
                w_ctlNext[0] = 1'b1;
                w_ctlNext[2] = w_ctlNext[2] | r_ctl[0];
            end
        end

        // Channel registers: counter, limit and control.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt <= '0;
                r_lim <= '0;
                r_ctl <= CTL_RESET_VALUE;
            end else begin
                if (w_cntWr) begin
                    r_cnt <= dBus;
                end else if (w_tick & r_ctl[1]) begin
                    r_cnt <= w_expire ? '0 : r_cnt + DBUS_WIDTH'(1);
                end
                if (w_limWr) begin
                    r_lim <= dBus;
                end
                r_ctl <= w_ctlNext;
            end
        end

        assign w_rdHitCh[i]  = ~wrtEn & (w_cntSel | w_limSel | w_ctlSel);
        assign w_rdDataCh[i] = w_cntSel ? r_cnt :
                               w_limSel ? r_lim :
                               w_ctlSel ? DBUS_WIDTH'(r_ctl) : '0;
        assign w_irqCh[i]    = r_ctl[0] & r_ctl[8];
    end

    // Read mux: unselected channels contribute zero, so a plain OR merges them.
    always_comb begin
        w_rdData = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_rdData = w_rdData | w_rdDataCh[k];
        end
    end

    assign w_rdHit = |w_rdHitCh;
    assign dBus    = w_rdHit ? w_rdData : 'z;

    // Registered interrupt request.
    always_ff @(posedge clk) begin
        if (reset) begin
            intr <= 1'b0;
        end else begin
            intr <= |w_irqCh;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_timer
// Brief    : Self-checking bench for multi_timer (TICK_DIV=4, NUM_CH=2):
//            directed scenarios with literal expectations, then random bus
//            traffic against a behavioural model of the timer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_timer;

    localparam int          c_NCH   = 2;
    localparam logic [31:0] c_FLOAT = 32'hFFFF_FFFF;  // undriven bus, pulled up

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] aBus;
    logic        wrtEn;
    logic [31:0] tbData;
    logic        tbDrv;
    wire  [31:0] dBus;
    logic        intr;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] lastRd;

    // Behavioural model state
    bit          mValid = 1'b0;
    logic [31:0] mPresc;
    logic [31:0] mCnt [c_NCH];
    logic [31:0] mLim [c_NCH];
    bit mReady [c_NCH];
    bit mRun   [c_NCH];
    bit mOvf   [c_NCH];
    bit mOne   [c_NCH];
    bit mIe    [c_NCH];
    bit mIntr;

    multi_timer #(
        .ABUS_WIDTH(32), .DBUS_WIDTH(32), .NUM_CH(c_NCH), .TICK_DIV(32'd4),
        .CNT_BASE(32'hF0000020), .CTL_BASE(32'hF0000120), .CTL_RESET_VALUE(9'h002)
    ) dut (
        .clk(clk), .reset(reset), .aBus(aBus), .dBus(dBus), .wrtEn(wrtEn), .intr(intr)
    );

    assign dBus = tbDrv ? tbData : 'z;
    for (genvar g = 0; g < 32; g++) begin : g_pu
        pullup (dBus[g]);
    end

    always #5 clk = ~clk;

    function automatic logic [31:0] cntAddr(int i); return 32'hF0000020 + 32'(8 * i); endfunction
    function automatic logic [31:0] limAddr(int i); return 32'hF0000024 + 32'(8 * i); endfunction
    function automatic logic [31:0] ctlAddr(int i); return 32'hF0000120 + 32'(4 * i); endfunction

    function automatic logic [31:0] mCtl(int i);
        return {23'd0, mIe[i], 3'd0, mOne[i], 1'b0, mOvf[i], mRun[i], mReady[i]};
    endfunction

    function automatic logic [31:0] mRead(logic [31:0] a);
        logic [31:0] v = c_FLOAT;
        for (int i = 0; i < c_NCH; i++) begin
            if (a == cntAddr(i)) v = mCnt[i];
            if (a == limAddr(i)) v = mLim[i];
            if (a == ctlAddr(i)) v = mCtl(i);
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one rising edge given the inputs applied in that cycle.
    task automatic modelStep(input bit rst, input logic [31:0] a, input bit we, input logic [31:0] d);
        bit tick, newIntr, wrC, wrL, wrT, expd, oldReady;
        if (rst) begin
            mPresc = 0;
            mIntr  = 0;
            for (int i = 0; i < c_NCH; i++) begin
                mCnt[i] = 0; mLim[i] = 0;
                mReady[i] = 0; mRun[i] = 1; mOvf[i] = 0; mOne[i] = 0; mIe[i] = 0;
            end
            mValid = 1'b1;
            return;
        end
        tick    = (mPresc == 32'd3);
        newIntr = 0;
        for (int i = 0; i < c_NCH; i++) newIntr |= mReady[i] & mIe[i];
        mPresc = tick ? 32'd0 : mPresc + 32'd1;
        for (int i = 0; i < c_NCH; i++) begin
            wrC = we && (a == cntAddr(i));
            wrL = we && (a == limAddr(i));
            wrT = we && (a == ctlAddr(i));
            expd = tick && mRun[i] && (mLim[i] != 0) && (mCnt[i] == mLim[i] - 1) && !wrC;
            oldReady = mReady[i];
            if (wrC) mCnt[i] = d;
            else if (tick && mRun[i]) mCnt[i] = expd ? 32'd0 : mCnt[i] + 32'd1;
            if (wrL) mLim[i] = d;
            if (wrT) begin
                mReady[i] = mReady[i] & d[0];
                mOvf[i]   = mOvf[i] & d[2];
                mRun[i]   = d[1];
                mOne[i]   = d[4];
                mIe[i]    = d[8];
            end else if (expd && mOne[i]) begin
                mRun[i] = 0;
            end
            if (expd) begin
                mOvf[i]   = mOvf[i] | oldReady;
                mReady[i] = 1;
            end
        end
        mIntr = newIntr;
    endtask

    // One bus cycle: apply inputs, compare outputs, clock the DUT and the model.
    task automatic cycle(input bit rst, input logic [31:0] a, input bit we, input logic [31:0] d);
        reset = rst; aBus = a; wrtEn = we; tbData = d; tbDrv = we;
        #1;
        lastRd = dBus;
        if (mValid) begin
            check("dbus", dBus, we ? d : mRead(a));
            check("intr", {31'd0, intr}, {31'd0, mIntr});
        end
        @(posedge clk);
        modelStep(rst, a, we, d);
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d); cycle(0, a, 1, d); endtask
    task automatic rd(input logic [31:0] a); cycle(0, a, 0, 32'd0); endtask
    task automatic idle(); cycle(0, 32'd0, 0, 32'd0); endtask

    // Idle until channel 0 is one tick away from expiring.
    task automatic waitExpireEdge0();
        for (int k = 0; k < 200; k++) begin
            if (mPresc == 32'd3 && mRun[0] && mLim[0] != 0 && mCnt[0] == mLim[0] - 1) return;
            idle();
        end
        check("wait_expire0_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        reset = 1; aBus = 0; wrtEn = 0; tbData = 0; tbDrv = 0;
        @(negedge clk);
        cycle(1, 32'd0, 0, 32'd0);
        cycle(1, 32'd0, 0, 32'd0);

        // Reset state and free-run counting every 4 clocks
        rd(32'hF0000120); check("rst_ctl0", lastRd, 32'h002);
        rd(32'hF0000020); check("rst_cnt0", lastRd, 32'd0);
        idle(); idle();
        rd(32'hF0000020); check("cnt0_after4", lastRd, 32'd1);
        check("rst_intr", {31'd0, intr}, 32'd0);

        // Auto-reload with interrupt
        wr(32'hF0000024, 32'd3);
        wr(32'hF0000020, 32'd0);
        wr(32'hF0000120, 32'h102);
        for (int k = 0; k < 100 && !mReady[0]; k++) idle();
        rd(32'hF0000120); check("ready0", lastRd, 32'h103);
        check("intr_set", {31'd0, intr}, 32'd1);
        for (int k = 0; k < 100 && !mOvf[0]; k++) idle();
        rd(32'hF0000120); check("ovf0", lastRd, 32'h107);
        wr(32'hF0000120, 32'h102);
        rd(32'hF0000120); check("ctl0_clr", lastRd, 32'h102);
        check("intr_drop", {31'd0, intr}, 32'd0);

        // One-shot on channel 1
        wr(32'hF0000124, 32'h000);
        wr(32'hF000002C, 32'd2);
        wr(32'hF0000028, 32'd0);
        wr(32'hF0000124, 32'h012);
        for (int k = 0; k < 100 && mRun[1]; k++) idle();
        rd(32'hF0000124); check("oneshot_ctl1", lastRd, 32'h011);
        repeat (10) idle();
        rd(32'hF0000028); check("oneshot_cnt1", lastRd, 32'd0);

        // CNT write on the expiry tick wins and suppresses expiry
        waitExpireEdge0();
        idle();
        wr(32'hF0000120, 32'h102);
        waitExpireEdge0();
        wr(32'hF0000020, 32'd5);
        rd(32'hF0000020); check("cnt_wr_wins", lastRd, 32'd5);
        rd(32'hF0000120); check("no_ready", lastRd, 32'h102);

        // READY clear on an expiry cycle loses to the hardware set
        wr(32'hF0000020, 32'd0);
        waitExpireEdge0();
        wr(32'hF0000120, 32'h102);
        rd(32'hF0000120); check("ready_kept", lastRd, 32'h103);

        // Unmapped read floats; reset mid-count restores everything
        rd(32'hF0000030); check("unmapped", lastRd, c_FLOAT);
        cycle(1, 32'd0, 0, 32'd0);
        rd(32'hF0000120); check("rst2_ctl0", lastRd, 32'h002);
        rd(32'hF0000124); check("rst2_ctl1", lastRd, 32'h002);
        rd(32'hF0000020); check("rst2_cnt0", lastRd, 32'd0);
        rd(32'hF0000024); check("rst2_lim0", lastRd, 32'd0);

        // Random bus traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int unsigned ch, sel;
            bit rst, we;
            logic [31:0] a, d;
            rst = ($urandom_range(0, 299) == 0);
            ch  = $urandom_range(0, c_NCH - 1);
            sel = $urandom_range(0, 3);
            we  = ($urandom_range(0, 5) == 0);
            case (sel)
                0: begin
                    a = cntAddr(int'(ch));
                    d = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 7));
                end
                1: begin a = limAddr(int'(ch)); d = 32'($urandom_range(0, 6)); end
                2: begin a = ctlAddr(int'(ch)); d = 32'($urandom) & 32'h0000_01FF; end
                default: begin a = 32'($urandom); d = 32'($urandom); end
            endcase
            cycle(rst, a, we, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
